// File: rtl/scan_display_pwm_ctrl_pkg.sv
// Shared frame-state type and header codes for the scan display / motor PWM controller.
package scan_display_pwm_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DIGIT_DATA,
      ST_PWM_HI,
      ST_PWM_LO
   } frame_state_t;

   localparam logic [3:0] HDR_BLANK_ALL = 4'hE;
   localparam logic [3:0] HDR_PWM       = 4'hF;
   localparam logic [6:0] SEG_BLANK     = 7'h7F;

endpackage

// File: rtl/scan_display_pwm_ctrl_hex_to_7seg.sv
// Hex nibble to active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}.
module hex_to_7seg (
   input  logic [3:0] hex,
   output logic [6:0] seg_n
);

   always_comb begin
      case (hex)
         4'h0:    seg_n = 7'h40;
         4'h1:    seg_n = 7'h79;
         4'h2:    seg_n = 7'h24;
         4'h3:    seg_n = 7'h30;
         4'h4:    seg_n = 7'h19;
         4'h5:    seg_n = 7'h12;
         4'h6:    seg_n = 7'h02;
         4'h7:    seg_n = 7'h78;
         4'h8:    seg_n = 7'h00;
         4'h9:    seg_n = 7'h10;
         4'hA:    seg_n = 7'h08;
         4'hB:    seg_n = 7'h03;
         4'hC:    seg_n = 7'h46;
         4'hD:    seg_n = 7'h21;
         4'hE:    seg_n = 7'h06;
         default: seg_n = 7'h0E;
      endcase
   end

endmodule

// File: rtl/scan_display_pwm_ctrl.sv
// Nibble-framed command decoder driving a multiplexed 7-segment display and a motor PWM.
module scan_display_pwm_ctrl
   import scan_display_pwm_ctrl_pkg::*;
#(
   parameter int N_DIGITS = 4,
   parameter int SCAN_DIV = 50000,
   parameter int PWM_BITS = 8,
   parameter int TIMEOUT  = 1000000
) (
   input  logic                FPGA_clk,
   input  logic                FPGA_reset_n,
   input  logic [3:0]          nib_data,
   input  logic                nib_valid,
   output logic [6:0]          seg_n,
   output logic [N_DIGITS-1:0] dig_n,
   output logic                motor_pwm_signal,
   output logic                busy,
   output logic                frame_err
);

   localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int TW = $clog2(TIMEOUT);
   localparam int SW = $clog2(SCAN_DIV);
   localparam logic [TW-1:0]       TMO_LAST  = TW'(TIMEOUT - 1);
   localparam logic [SW-1:0]       SCAN_LAST = SW'(SCAN_DIV - 1);
   localparam logic [IW-1:0]       IDX_LAST  = IW'(N_DIGITS - 1);
   localparam logic [PWM_BITS-1:0] CNT_LAST  = PWM_BITS'((1 << PWM_BITS) - 2);

   frame_state_t        state, state_next;
   logic [IW-1:0]       target;
   logic [3:0]          digit [N_DIGITS];
   logic [N_DIGITS-1:0] blank;
   logic [3:0]          duty_hi;
   logic [PWM_BITS-1:0] duty_pending, duty_active, pwm_cnt;
   logic [TW-1:0]       tmo_cnt;
   logic [SW-1:0]       scan_cnt;
   logic [IW-1:0]       idx;
   logic [6:0]          seg_dec;
   logic                do_target, do_write, do_blank, do_hi, do_duty, tmo_hit;

   // The 8-bit {hi,lo} duty is truncated or zero-extended to the counter width.
   function automatic logic [PWM_BITS-1:0] fit_duty(input logic [7:0] raw);
      logic [15:0] wide;
      wide = {8'h00, raw};
      return wide[PWM_BITS-1:0];
   endfunction

   always_ff @(posedge FPGA_clk or negedge FPGA_reset_n) begin
      if (!FPGA_reset_n) state <= ST_IDLE;
      else               state <= state_next;
   end

   always_comb begin
      state_next = state;
      do_target  = 1'b0;
      do_write   = 1'b0;
      do_blank   = 1'b0;
      do_hi      = 1'b0;
      do_duty    = 1'b0;
      tmo_hit    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (nib_valid) begin
               if (nib_data < 4'(N_DIGITS)) begin
                  do_target  = 1'b1;
                  state_next = ST_DIGIT_DATA;
               end else if (nib_data == HDR_BLANK_ALL) begin
                  do_blank = 1'b1;
               end else if (nib_data == HDR_PWM) begin
                  state_next = ST_PWM_HI;
               end
            end
         end
         ST_DIGIT_DATA: begin
            if (nib_valid) begin
               do_write   = 1'b1;
               state_next = ST_IDLE;
            end else if (tmo_cnt == TMO_LAST) begin
               tmo_hit    = 1'b1;
               state_next = ST_IDLE;
            end
         end
         ST_PWM_HI: begin
            if (nib_valid) begin
               do_hi      = 1'b1;
               state_next = ST_PWM_LO;
            end else if (tmo_cnt == TMO_LAST) begin
               tmo_hit    = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: begin
            if (nib_valid) begin
               do_duty    = 1'b1;
               state_next = ST_IDLE;
            end else if (tmo_cnt == TMO_LAST) begin
               tmo_hit    = 1'b1;
               state_next = ST_IDLE;
            end
         end
      endcase
   end

   assign busy = (state != ST_IDLE);

   always_ff @(posedge FPGA_clk or negedge FPGA_reset_n) begin
      if (!FPGA_reset_n) begin
         tmo_cnt      <= '0;
         frame_err    <= 1'b0;
         blank        <= '1;
         duty_pending <= '0;
      end else begin
         frame_err <= tmo_hit;
         if (state == ST_IDLE || nib_valid || tmo_hit) tmo_cnt <= '0;
         else                                          tmo_cnt <= tmo_cnt + 1'b1;
         if (do_blank)      blank         <= '1;
         else if (do_write) blank[target] <= 1'b0;
         if (do_duty) duty_pending <= fit_duty({duty_hi, nib_data});
      end
   end

   // Payload registers; their contents are masked by blank / discarded by reset.
   always_ff @(posedge FPGA_clk) begin
      if (do_target) target        <= nib_data[IW-1:0];
      if (do_write)  digit[target] <= nib_data;
      if (do_hi)     duty_hi       <= nib_data;
   end

   hex_to_7seg u_hex_to_7seg (
      .hex   (digit[idx]),
      .seg_n (seg_dec)
   );

   // Scan path: seg_n and dig_n are registered together from the same idx.
   always_ff @(posedge FPGA_clk or negedge FPGA_reset_n) begin
      if (!FPGA_reset_n) begin
         scan_cnt <= '0;
         idx      <= '0;
         seg_n    <= SEG_BLANK;
         dig_n    <= ~N_DIGITS'(1);
      end else begin
         if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end else begin
            scan_cnt <= scan_cnt + 1'b1;
         end
         seg_n <= blank[idx] ? SEG_BLANK : seg_dec;
         dig_n <= ~(N_DIGITS'(1) << idx);
      end
   end

   // PWM: duty changes only at the period boundary so no period is cut short.
   always_ff @(posedge FPGA_clk or negedge FPGA_reset_n) begin
      if (!FPGA_reset_n) begin
         pwm_cnt          <= '0;
         duty_active      <= '0;
         motor_pwm_signal <= 1'b0;
      end else begin
         if (pwm_cnt == CNT_LAST) begin
            pwm_cnt     <= '0;
            duty_active <= duty_pending;
         end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
         end
         motor_pwm_signal <= (pwm_cnt < duty_active);
      end
   end

endmodule

// File: doc/scan_display_pwm_ctrl.md
SCAN_DISPLAY_PWM_CTRL -- requirements
Module: scan_display_pwm_ctrl

Interface
REQ-001 Parameter N_DIGITS, default 4, number of multiplexed 7-seg digits, legal range 1..14.
REQ-002 Parameter SCAN_DIV, default 50000, clock cycles each digit stays selected, minimum 2.
REQ-003 Parameter PWM_BITS, default 8, PWM duty and counter width, legal range 2..16.
REQ-004 Parameter TIMEOUT, default 1000000, max idle cycles between nibbles inside a frame, minimum 2.
REQ-005 FPGA_clk  in  1  sole clock; all logic on its rising edge.
REQ-006 FPGA_reset_n  in  1  asynchronous, active-low reset.
REQ-007 nib_data  in  4  nibble from the SPI slave; sampled only when nib_valid=1.
REQ-008 nib_valid  in  1  single-cycle strobe; one nibble per high cycle.
REQ-009 seg_n  out  7  segment pattern for the selected digit, active-low; 7'h7F means blank.
REQ-010 dig_n  out  N_DIGITS  one-hot-low digit enable.
REQ-011 motor_pwm_signal  out  1  PWM output.
REQ-012 busy  out  1  high while the frame FSM is not in IDLE.
REQ-013 frame_err  out  1  one-cycle pulse when a frame aborts on timeout.

Function
REQ-014 Frame FSM states SHALL be IDLE, DIGIT_DATA, PWM_HI and PWM_LO; each nib_valid advances at most one transition.
REQ-015 In IDLE, header h<N_DIGITS SHALL latch target index h and go to DIGIT_DATA.
REQ-016 In IDLE, h=4'hE SHALL blank all digits in that cycle and stay in IDLE.
REQ-017 In IDLE, h=4'hF SHALL go to PWM_HI.
REQ-018 In IDLE, any other header SHALL be ignored silently, with no state change and no error.
REQ-019 In DIGIT_DATA, a nibble SHALL be stored into digit[target], mark that digit non-blank, and return to IDLE.
REQ-020 In PWM_HI, the nibble SHALL be held as the duty high nibble, then the FSM goes to PWM_LO.
REQ-021 In PWM_LO, the nibble SHALL complete duty_pending = {hi,lo} and return to IDLE.
REQ-022 Width rule: duty_pending is the 8-bit value truncated to PWM_BITS LSBs when PWM_BITS<8, and zero-extended when PWM_BITS>8.
REQ-023 Timeout: a per-nibble counter SHALL restart on each nib_valid outside IDLE.
REQ-024 If the counter reaches TIMEOUT cycles with no nibble, the FSM SHALL go to IDLE, pulse frame_err, and change no stored state.
REQ-025 Scan: a divider SHALL advance the digit index every SCAN_DIV cycles, wrapping N_DIGITS-1→0.
REQ-026 With N_DIGITS=1, dig_n SHALL stay 0.
REQ-027 seg_n SHALL be registered: the hex_to_7seg decode of digit[idx], or 7'h7F when digit[idx] is blank.
REQ-028 dig_n SHALL update in the same cycle as seg_n, and no two digits are ever enabled at once.
REQ-029 A digit write SHALL be visible on seg_n within one cycle of that digit being selected, including when the write targets the currently selected digit.
REQ-030 A write and a blank-all SHALL never coincide, since each nib_valid carries one nibble.
REQ-031 PWM counter SHALL count 0..2^PWM_BITS-2 and wrap, giving a period of 2^PWM_BITS-1 cycles.
REQ-032 motor_pwm_signal SHALL be registered and equal (cnt < duty_active).
REQ-033 duty 0 SHALL hold the output constantly low; duty of all ones SHALL hold it constantly high.
REQ-034 duty_active SHALL load duty_pending only when the counter wraps to 0, so no glitched periods occur; the update applies from the next period.

Reset
REQ-035 Reset assertion SHALL asynchronously force: FSM=IDLE, all digits blank, idx=0, scan and PWM counters=0, and duty_pending=duty_active=0.
REQ-036 During reset the outputs SHALL be seg_n=7'h7F, dig_n with bit0 low and others high, motor_pwm_signal=0, busy=0, frame_err=0.
REQ-037 Reset mid-frame SHALL discard the partial frame; the first nibble after release is treated as a header.
REQ-038 Reset deassertion is expected synchronous to FPGA_clk; the block contains no internal synchronizer.

Structure
REQ-039 A shared package SHALL hold the FSM state enum and the header constants HDR_BLANK_ALL=4'hE and HDR_PWM=4'hF.
REQ-040 The existing hex_to_7seg decoder SHALL be instantiated once as the sole sub-module, on the scan path.
REQ-041 The PWM generator and the scan divider stay inline.

Verification (N_DIGITS=4, SCAN_DIV=4, PWM_BITS=4, TIMEOUT=16)
REQ-042 Write digit: nibbles 2,A → digit2 non-blank; when dig_n=4'b1011, seg_n=decode(A); other digits show 7'h7F.
REQ-043 Blank-all: write digits 0..3, then send E → every scan slot shows seg_n=7'h7F within one full scan of 16 cycles.
REQ-044 PWM: nibbles F,0,5 → after the next counter wrap, output is high for 5 of every 15 cycles; duty 0 gives constant 0; nibbles F,0,F give constant 1.
REQ-045 Timeout: send F,3, then wait 16 cycles → frame_err pulses once, busy falls, duty is unchanged; the next nibble 1 is treated as a header.
REQ-046 Reset mid-frame: send 1, then pulse reset → all outputs take reset values immediately; then 0,7 → digit0 shows decode(7).
REQ-047 Ignored header: send 5 (≥N_DIGITS) → no state change, busy stays 0, frame_err stays 0.
